// File: rtl/mem_req_queue_pkg.sv
// Shared types for the memory request queue: operation enum, queued request struct, FSM states.
// Optional performance counters in mem_req_queue are enabled with MEM_REQ_QUEUE_PERF_EN.
package mem_req_queue_pkg;

    localparam int MRQ_ADDR_W = 32;
    localparam int MRQ_DATA_W = 32;
    localparam int MRQ_TAG_W  = 4;
    localparam int MRQ_BSEL_W = MRQ_DATA_W / 8;

    typedef enum logic [1:0] {
        MEM_OP_BYTE = 2'd0,
        MEM_OP_HALF = 2'd1,
        MEM_OP_WORD = 2'd2,
        MEM_OP_BU   = 2'd3
    } mem_op_t;

    typedef struct packed {
        logic                  is_store;
        mem_op_t               op;
        logic [MRQ_ADDR_W-1:0] addr;
        logic [MRQ_DATA_W-1:0] wdata;
        logic [MRQ_BSEL_W-1:0] bsel;
        logic [MRQ_TAG_W-1:0]  tag;
    } mem_req_t;

    typedef enum logic [2:0] {
        MQS_IDLE    = 3'd0,
        MQS_ISSUE   = 3'd1,
        MQS_WAIT    = 3'd2,
        MQS_BACKOFF = 3'd3,
        MQS_RESP    = 3'd4
    } mqs_state_e;

    // Width of a counter that must hold values 0..max_val (never narrower than 1 bit).
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/mem_req_fifo.sv
// Request storage for mem_req_queue: DEPTH-entry circular buffer, head entry visible combinationally.
module mem_req_fifo
    import mem_req_queue_pkg::*;
#(
    parameter int DEPTH = 4
)(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  mem_req_t               din,
    output mem_req_t               dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int                PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0]    FULL_CNT = (PTR_W + 1)'(DEPTH);

    mem_req_t         r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    // NOTE: the storage array is deliberately not reset; pointers and count alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            // Power-of-two DEPTH lets the pointers wrap by plain overflow.
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign dout  = r_mem[r_rd_ptr];
    assign full  = (r_count == FULL_CNT);
    assign empty = (r_count == '0);
    assign count = r_count;

endmodule

// File: rtl/mem_req_queue.sv
// In-order tagged load/store queue between Dispatch and the data SRAM, with fixed back-off miss retry.
// Define MEM_REQ_QUEUE_PERF_EN to add saturating perf_hits/perf_misses/perf_retries counters.
module mem_req_queue
    import mem_req_queue_pkg::*;
#(
    parameter int ADDR_W      = MRQ_ADDR_W,
    parameter int DATA_W      = MRQ_DATA_W,
    parameter int DEPTH       = 4,
    parameter int TAG_W       = MRQ_TAG_W,
    parameter int MAX_RETRY   = 3,
    parameter int RETRY_DELAY = 4
)(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                disp_req_valid,
    output logic                disp_req_ready,
    input  logic                disp_req_is_store,
    input  mem_op_t             disp_req_op,
    input  logic [ADDR_W-1:0]   disp_req_addr,
    input  logic [DATA_W-1:0]   disp_req_wdata,
    input  logic [DATA_W/8-1:0] disp_req_bsel,
    input  logic [TAG_W-1:0]    disp_req_tag,
    output logic                disp_resp_valid,
    output logic [TAG_W-1:0]    disp_resp_tag,
    output logic [DATA_W-1:0]   disp_resp_data,
    output logic                disp_resp_hit,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic                mem_req_is_store,
    output mem_op_t             mem_req_op,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic [DATA_W-1:0]   mem_req_wdata,
    output logic [DATA_W/8-1:0] mem_req_bsel,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_resp_data,
    input  logic                mem_resp_hit
`ifdef MEM_REQ_QUEUE_PERF_EN
    ,
    output logic [31:0]         perf_hits,
    output logic [31:0]         perf_misses,
    output logic [31:0]         perf_retries
`endif
);

    localparam int CNT_W   = $clog2(DEPTH) + 1;
    localparam int RETRY_W = cnt_w(MAX_RETRY);
    localparam int DELAY_W = cnt_w(RETRY_DELAY);

    // The queued struct is sized by the package, so the port widths must agree with it.
    if ((ADDR_W != MRQ_ADDR_W) || (DATA_W != MRQ_DATA_W) || (TAG_W != MRQ_TAG_W)) begin : g_width_check
        $error("mem_req_queue: ADDR_W/DATA_W/TAG_W must match mem_req_queue_pkg");
    end
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (RETRY_DELAY < 1)) begin : g_cfg_check
        $error("mem_req_queue: DEPTH must be a power of two >= 2 and RETRY_DELAY >= 1");
    end

    mqs_state_e         r_state;
    mqs_state_e         w_next_state;
    mem_req_t           w_din;
    mem_req_t           w_head;
    logic               w_full;
    logic               w_empty;
    logic [CNT_W-1:0]   w_count;
    logic               w_push;
    logic               w_pop;
    logic               w_resp_final;
    logic               w_miss_retry;
    logic [RETRY_W-1:0] r_retry_cnt;
    logic [DELAY_W-1:0] r_delay_cnt;
    logic [DATA_W-1:0]  r_resp_data;
    logic               r_resp_hit;

    assign w_din = '{
        is_store: disp_req_is_store,
        op:       disp_req_op,
        addr:     disp_req_addr,
        wdata:    disp_req_wdata,
        bsel:     disp_req_bsel,
        tag:      disp_req_tag
    };

    assign disp_req_ready = !w_full;
    assign w_push         = disp_req_valid && !w_full;
    assign w_pop          = (r_state == MQS_RESP);

    mem_req_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_din),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    // The final attempt reports whatever the SRAM says; earlier misses go to back-off.
    assign w_resp_final = (r_state == MQS_WAIT) && mem_resp_valid &&
                          (mem_resp_hit || (r_retry_cnt == RETRY_W'(MAX_RETRY)));
    assign w_miss_retry = (r_state == MQS_WAIT) && mem_resp_valid && !w_resp_final;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= MQS_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: the next state is defaulted before the case so no path leaves it unassigned (no latch).
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            MQS_IDLE: begin
                // Looking at the push as well saves a cycle on an empty queue.
                if (w_push || !w_empty) begin
                    w_next_state = MQS_ISSUE;
                end
            end
            MQS_ISSUE: begin
                if (mem_req_ready) begin
                    w_next_state = MQS_WAIT;
                end
            end
            MQS_WAIT: begin
                if (w_resp_final) begin
                    w_next_state = MQS_RESP;
                end else if (w_miss_retry) begin
                    w_next_state = MQS_BACKOFF;
                end
            end
            MQS_BACKOFF: begin
                if (r_delay_cnt <= DELAY_W'(1)) begin
                    w_next_state = MQS_ISSUE;
                end
            end
            MQS_RESP: begin
                if (w_push || (w_count > CNT_W'(1))) begin
                    w_next_state = MQS_ISSUE;
                end else begin
                    w_next_state = MQS_IDLE;
                end
            end
            default: w_next_state = MQS_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retry_cnt <= '0;
            r_delay_cnt <= '0;
            r_resp_data <= '0;
            r_resp_hit  <= 1'b0;
        end else begin
            if (w_miss_retry) begin
                r_retry_cnt <= r_retry_cnt + 1'b1;
                r_delay_cnt <= DELAY_W'(RETRY_DELAY);
            end else if ((r_state == MQS_BACKOFF) && (r_delay_cnt != '0)) begin
                r_delay_cnt <= r_delay_cnt - 1'b1;
            end
            if (w_resp_final) begin
                r_resp_data <= mem_resp_data;
                r_resp_hit  <= mem_resp_hit;
            end
            if (r_state == MQS_RESP) begin
                r_retry_cnt <= '0;
            end
        end
    end

    // Request fields are zeroed while idle so nothing stale from storage leaks onto the SRAM bus.
    assign mem_req_valid    = (r_state == MQS_ISSUE);
    assign mem_req_is_store = mem_req_valid && w_head.is_store;
    assign mem_req_op       = mem_req_valid ? w_head.op    : MEM_OP_BYTE;
    assign mem_req_addr     = mem_req_valid ? w_head.addr  : '0;
    assign mem_req_wdata    = mem_req_valid ? w_head.wdata : '0;
    assign mem_req_bsel     = mem_req_valid ? w_head.bsel  : '0;

    assign disp_resp_valid = (r_state == MQS_RESP);
    assign disp_resp_tag   = disp_resp_valid ? w_head.tag : '0;
    assign disp_resp_data  = (disp_resp_valid && !w_head.is_store) ? r_resp_data : '0;
    assign disp_resp_hit   = disp_resp_valid && r_resp_hit;

`ifdef MEM_REQ_QUEUE_PERF_EN
    logic [31:0] r_perf_hits;
    logic [31:0] r_perf_misses;
    logic [31:0] r_perf_retries;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_hits    <= '0;
            r_perf_misses  <= '0;
            r_perf_retries <= '0;
        end else begin
            if ((r_state == MQS_RESP) && r_resp_hit && (r_perf_hits != '1)) begin
                r_perf_hits <= r_perf_hits + 1'b1;
            end
            if ((r_state == MQS_RESP) && !r_resp_hit && (r_perf_misses != '1)) begin
                r_perf_misses <= r_perf_misses + 1'b1;
            end
            if (w_miss_retry && (r_perf_retries != '1)) begin
                r_perf_retries <= r_perf_retries + 1'b1;
            end
        end
    end

    assign perf_hits    = r_perf_hits;
    assign perf_misses  = r_perf_misses;
    assign perf_retries = r_perf_retries;
`endif

endmodule

// File: doc/mem_req_queue.md
Name: mem_req_queue

Overview:
- Parametrised successor to the single-request dispatch/wakeup memory link. Buffers up to DEPTH tagged load/store requests from Dispatch and issues them in order, one outstanding at a time, to the data SRAM port.
- Retries SRAM misses with a fixed back-off and returns a tagged, in-order response (data, hit) to Dispatch.
- Sits between Dispatch and the data SRAM/Wakeup path.

Parameters:
- ADDR_W, 32, memory address width
- DATA_W, 32, data width; must be a multiple of 8
- DEPTH, 4, queue entries; power of two, ≥2
- TAG_W, 4, request tag width
- MAX_RETRY, 3, miss retries before a miss is reported
- RETRY_DELAY, 4, back-off cycles between retries; ≥1

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- disp_req_valid  in  1  request present
- disp_req_ready  out  1  queue can accept
- disp_req_is_store  in  1  1 = store, 0 = load
- disp_req_op  in  $bits(mem_op_t)  operation type
- disp_req_addr  in  ADDR_W  address
- disp_req_wdata  in  DATA_W  store data
- disp_req_bsel  in  DATA_W/8  byte select
- disp_req_tag  in  TAG_W  request tag
- disp_resp_valid  out  1  one-cycle response pulse
- disp_resp_tag  out  TAG_W  tag of the completed request
- disp_resp_data  out  DATA_W  load data; 0 for stores
- disp_resp_hit  out  1  1 = hit; 0 = gave up after MAX_RETRY retries
- mem_req_valid  out  1  SRAM request valid
- mem_req_ready  in  1  SRAM accepts
- mem_req_is_store, mem_req_op, mem_req_addr, mem_req_wdata, mem_req_bsel  out  as disp_req_*  head-entry fields
- mem_resp_valid  in  1  SRAM response
- mem_resp_data  in  DATA_W  read data
- mem_resp_hit  in  1  hit indicator

Behaviour:
- Reset: all outputs 0 except disp_req_ready, which is 1. Pointers, count, retry_cnt and delay counter cleared. FSM goes to IDLE.
- Queue:
  - disp_req_ready = !full.
  - Enqueue on valid & ready.
  - When full, no enqueue, even if a pop occurs in the same cycle.
  - Pointers wrap modulo DEPTH. Count width is $clog2(DEPTH)+1.
- FSM states: IDLE, ISSUE, WAIT, BACKOFF, RESP.
  - IDLE → ISSUE when the queue is non-empty.
  - Enqueue into an empty IDLE queue at cycle N gives mem_req_valid=1 at cycle N+1.
- ISSUE:
  - mem_req_valid=1; mem_req_* driven from the head entry and held stable until mem_req_ready.
  - On mem_req_ready → WAIT.
- WAIT (mem_req_valid=0):
  - On mem_resp_valid with hit=1, or with retry_cnt==MAX_RETRY: latch data/hit → RESP.
  - On a miss with retry_cnt<MAX_RETRY: retry_cnt++, load the delay counter with RETRY_DELAY → BACKOFF.
- BACKOFF: decrement the delay counter each cycle; at 0 → ISSUE.
- RESP:
  - disp_resp_valid=1 for exactly one cycle with the head tag, latched data (forced to 0 for stores) and latched hit.
  - Pop the head, clear retry_cnt.
  - → ISSUE if still non-empty after the pop, else IDLE.
  - No back-pressure on responses.
- mem_resp_valid outside WAIT is ignored.
- Responses are strictly in enqueue order.
- Reset asserted mid-operation: the queue is flushed. Any SRAM response arriving after reset is ignored because the FSM is in IDLE.

Optional Feature:
- Macro: MEM_REQ_QUEUE_PERF_EN.
- Defined: adds outputs perf_hits, perf_misses and perf_retries, each 32 bits.
  - perf_hits increments on a RESP with hit=1.
  - perf_misses increments on a RESP with hit=0.
  - perf_retries increments on each WAIT→BACKOFF transition.
  - All three saturate at all-ones and reset to 0.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- CORE_PKG holds:
  - mem_op_t enum
  - mem_req_t struct (is_store, op, addr, wdata, bsel, tag), parameterised via package constants
  - mqs_state_e FSM enum
- Storage sub-module mem_req_fifo, parameterised on DEPTH:
  - ports clk, rst_n, push, pop, din, dout, full, empty
  - no read latency; head visible combinationally

Test Plan:
- Single load, SRAM accepts immediately and returns hit=1, data=0xDEADBEEF after 2 cycles → disp_resp_valid pulse, tag=3, data=0xDEADBEEF, hit=1; mem_req_valid seen exactly once.
- Push 5 requests back-to-back with DEPTH=4 and mem_req_ready=0 → disp_req_ready drops after the 4th enqueue. Then release ready → 4 responses with tags in enqueue order 0,1,2,3; 5th accepted after the first pop.
- Load misses twice then hits → two BACKOFF gaps of 4 cycles each between mem_req_valid assertions; response hit=1; perf_retries=2 when MEM_REQ_QUEUE_PERF_EN is defined.
- Load misses 4 times with MAX_RETRY=3 → exactly 4 SRAM issues; response hit=0; perf_misses=1.
- Store with bsel=4'b0011, wdata=0x12345678, hit=1 → mem_req_wdata/mem_req_bsel match the inputs; disp_resp_data=0.
- Assert rst_n=0 during WAIT with 2 entries queued, then deliver mem_resp_valid after release → no disp_resp_valid; disp_req_ready=1; queue empty.
